// File: rtl/bos_emu_pkg.sv
// bos_emu_pkg: shared types, widths and offset saturation for the BOS emulator.
package bos_emu_pkg;
    typedef enum logic {IDLE, HAVE_BLACK} state_t;
    localparam int VID_W = 14;
    localparam int Q_W = 12;
    localparam int CNT_W = 12;
    localparam int OFS_W = 16;
    localparam int OFS_MAX = 4095;
    function automatic logic signed [OFS_W-1:0] sat_ofs(input logic signed [17:0] x);
        return x > 18'(OFS_MAX) ? OFS_W'(OFS_MAX) : x < -18'(OFS_MAX) ? -OFS_W'(OFS_MAX) : $signed(x[OFS_W-1:0]);
    endfunction
endpackage

// File: rtl/bos_emu_delay_line.sv
// bos_emu_delay_line: DEPTH-stage shift register advancing only when en is high.
module bos_emu_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/bos_emulator.sv
// bos_emulator: behavioural BOS front end (CDS, black clamp, 12-bit quantiser, pixel pipeline).
// Defining BOS_EMU_CLAMP_EN enables the clamp loop; otherwise offset stays 0.
module bos_emulator
    import bos_emu_pkg::*;
#(
    parameter int          PIPE_DELAY   = 3,
    parameter logic [11:0] CLAMP_TARGET = 12'd64,
    parameter int          CLAMP_SHIFT  = 3
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             clk_fpga,
    input  logic             shp_fpga,
    input  logic             shd_fpga,
    input  logic             clpdm_fpga,
    input  logic             hd_fpga,
    input  logic             vd_fpga,
    input  logic [VID_W-1:0] video_in,
    input  logic             err_clr,
    output logic             dataclk_fpga,
    output logic [Q_W-1:0]   q_fpga,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] line_cnt,
    output logic             seq_err
);
`ifdef BOS_EMU_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif
    logic clk_d, shp_d, shd_d, hd_d, vd_d;
    logic clk_r, shp_r, shd_r, hd_r, vd_r, viol;
    state_t state;
    logic [VID_W-1:0] black, video;
    logic pix_done, sc_v, sc_clp;
    logic signed [12:0] scaled;
    logic signed [16:0] sum;
    logic signed [17:0] err;
    logic signed [OFS_W-1:0] offset;
    logic [Q_W-1:0] q, hold;

    assign clk_r = clk_fpga & ~clk_d;
    assign shp_r = shp_fpga & ~shp_d;
    assign shd_r = shd_fpga & ~shd_d;
    assign hd_r  = hd_fpga & ~hd_d;
    assign vd_r  = vd_fpga & ~vd_d;
    assign viol  = (shp_r & shd_r) | (state == IDLE ? shd_r : shp_r);
    assign sum   = 17'(scaled) + 17'(offset);
    assign q     = sum[16] ? '0 : |sum[15:12] ? '1 : sum[11:0];
    assign err   = ($signed({6'd0, CLAMP_TARGET}) - 18'(sum)) >>> CLAMP_SHIFT;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            {clk_d, shp_d, shd_d, hd_d, vd_d, dataclk_fpga} <= '0;
            state <= IDLE;
            black <= '0;
            video <= '0;
            pix_done <= 1'b0;
            scaled <= '0;
            sc_v <= 1'b0;
            sc_clp <= 1'b0;
            offset <= '0;
            hold <= '0;
            pix_cnt <= '0;
            line_cnt <= '0;
            seq_err <= 1'b0;
        end else begin
            {clk_d, shp_d, shd_d, hd_d, vd_d} <= {clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga};
            dataclk_fpga <= clk_d;
            seq_err <= (seq_err & ~err_clr) | viol;
            pix_done <= state == HAVE_BLACK && shd_r && !shp_r;
            if (shp_r && !shd_r) begin
                black <= video_in;
                state <= HAVE_BLACK;
            end else if (shd_r && !shp_r && state == HAVE_BLACK) begin
                video <= video_in;
                state <= IDLE;
            end
            // CDS difference is stored already divided by 4 (arithmetic shift)
            scaled <= 13'(($signed({1'b0, black}) - $signed({1'b0, video})) >>> 2);
            sc_v <= pix_done;
            sc_clp <= pix_done & clpdm_fpga;
            if (sc_v) hold <= q;
            if (CLAMP_ON && sc_clp) offset <= sat_ofs(18'(offset) + err);
            pix_cnt <= hd_r ? '0 : pix_cnt + CNT_W'(pix_done);
            line_cnt <= vd_r ? '0 : line_cnt + CNT_W'(hd_r);
        end
    end

    bos_emu_delay_line #(.DEPTH(PIPE_DELAY), .WIDTH(Q_W)) u_dly (
        .clk(sys_clk),
        .rst(rst),
        .en(clk_r),
        .d(hold),
        .q(q_fpga)
    );
endmodule
